pre_mem_stage: RTL and testbench
================================

# pre_mem_stage

Pre-memory pipeline stage between EXE and MEM. It latches the EXE result and checks load/store address alignment. It issues the data-memory request with a req/addr_ok handshake and passes the instruction, with any exception, on to MEM. A flush never abandons an issued request; the stage drains it and tells MEM to discard the matching response.

## Interface
No parameters.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- es_to_pms_valid  in  1  EXE holds a completed instruction
- pms_allowin  out  1  stage can accept from EXE this cycle
- es_load_op  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW
- es_store_op  in  2  0 none, 1 SB, 2 SH, 3 SW
- es_addr  in  32  effective address (ALU result)
- es_wdata  in  32  rt value for stores
- es_dest  in  5  destination register, 0 = none
- es_result  in  32  final result for non-load instructions
- es_pc  in  32  instruction PC
- es_ex  in  1  exception already raised upstream
- es_exccode  in  5  upstream exception code
- es_badvaddr  in  32  upstream bad virtual address
- flush  in  1  exception/eret flush
- ms_allowin  in  1  MEM can accept
- pms_to_ms_valid  out  1  handoff valid
- ms_load_op, ms_dest, ms_result, ms_pc, ms_addr_low[1:0], ms_ex, ms_exccode, ms_badvaddr  out  widths as inputs  registered fields to MEM
- ms_req_sent  out  1  a memory request was accepted for this instruction; MEM waits for data_ok
- discard_resp  out  1  one-cycle pulse: next data_ok belongs to a flushed request
- pms_wr_disable  out  1  stage holds a valid excepting instruction
- fwd_dest  out  5  ms_dest gated by valid
- fwd_is_load  out  1  valid load in stage (EXE/ID must stall rather than forward)
- data_req  out  1  request valid
- data_wr  out  1  1 = store
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  request address
- data_wstrb  out  4  byte strobes, 0 for loads
- data_wdata  out  32  store data, lane-replicated
- data_addr_ok  in  1  request accepted this cycle

## Operation
- Internal registers: pms_valid, captured fields, and state ∈ {IDLE, REQ, DONE, DRAIN}.
- Capture: fields load when es_to_pms_valid & pms_allowin. pms_valid <= es_to_pms_valid when pms_allowin.
- Alignment: an exception is raised when LH/LHU/SH has addr[0]≠0, or when LW/SW has addr[1:0]≠0.
  - Exccode is 4 (AdEL) for loads and 5 (AdES) for stores.
  - badvaddr = addr.
  - An upstream es_ex takes priority and keeps its own code and badvaddr.
  - The exception is computed at capture and registered.
- mem_op = load_op≠0 | store_op≠0.
- need_req = pms_valid & mem_op & ~ms_ex.
- State transitions:
  - IDLE → REQ on capture of an instruction with need_req.
  - REQ → DONE on data_addr_ok.
  - REQ → DRAIN on flush without data_addr_ok.
  - REQ & flush & data_addr_ok: discard_resp pulses in that cycle and the next state is IDLE.
  - DRAIN → IDLE on data_addr_ok, with the discard_resp pulse in that cycle.
  - DONE → IDLE on handoff.
- data_req = state∈{REQ, DRAIN}. While data_req=1, all data_* fields must stay stable until addr_ok.
- Request signals:
  - data_wr = store.
  - data_size: LB/LBU/SB → 0, LH/LHU/SH → 1, LW/SW → 2.
  - data_addr = captured address.
- Stores:
  - SB: wstrb = 1<<addr[1:0], wdata = {4{byte}}.
  - SH: wstrb = addr[1] ? 1100 : 0011, wdata = {2{half}}.
  - SW: wstrb = 1111, wdata = rt.
- ready_go:
  - pms_valid & (~need_req | state==DONE | (state==REQ & data_addr_ok)).
  - If ready_go comes from REQ & data_addr_ok and MEM is blocked, the state becomes DONE.
- Handshakes:
  - pms_to_ms_valid = ready_go & ~flush.
  - pms_allowin = (state≠DRAIN) & (~pms_valid | ready_go & ms_allowin).
- ms_req_sent = mem_op & ~ms_ex.
- pms_wr_disable = pms_valid & ms_ex.
- Flush: pms_valid is cleared next cycle. Capture is blocked during the flush cycle. An IDLE/DONE state goes to IDLE; REQ goes to DRAIN (or IDLE per above).

## Timing
- Reset: pms_valid=0, state=IDLE; data_req=0, discard_resp=0, pms_to_ms_valid=0, pms_wr_disable=0, fwd_is_load=0, fwd_dest=0. Data fields are don't-care.
- Non-memory instruction: captured at edge N, handed to MEM in cycle N+1 if ms_allowin.
- Memory instruction: data_req is high from cycle N+1. With addr_ok in N+1, handoff is in N+1. Each cycle without addr_ok adds one cycle.
- No new request is issued while in DRAIN. pms_allowin stays 0 until the drain completes.
- Back-to-back memory ops issue one request per cycle when addr_ok is constantly high.

## Test plan
- LW addr 0x1000_0004, addr_ok held high -> data_req in N+1 with size 2, wstrb 0, wr 0; pms_to_ms_valid in N+1; ms_req_sent=1.
- SB addr 0x...3, rt 0x0000_00A5 -> wstrb 1000, wdata 0xA5A5_A5A5. SH addr 0x...2, rt 0x1234 -> wstrb 1100, wdata 0x1234_1234.
- LH addr 0x...1 -> no data_req; ms_ex=1, exccode 4, badvaddr 0x...1; pms_wr_disable=1. SW addr 0x...2 -> exccode 5.
- SW with addr_ok low for 3 cycles, then high -> data_req and all fields stable for 4 cycles; handoff in the 4th cycle; pms_allowin low meanwhile.
- LW in REQ, flush while addr_ok=0, then addr_ok 2 cycles later -> no pms_to_ms_valid; discard_resp pulses exactly once in the addr_ok cycle; pms_allowin=0 until then.
- ADD (dest 8) behind a stalled MEM (ms_allowin=0) for 2 cycles -> fields held, fwd_dest=8, handoff when ms_allowin rises; reset mid-REQ -> data_req=0 the next cycle.

Source files
------------

// File: rtl/pre_mem_stage_if.sv
// pre_mem_stage_if
//   Data-memory request bus between the pre-memory stage and the data memory.
//   master: the pre-memory stage (drives the request fields)
//   slave : the data memory (drives data_addr_ok)
//
//   Handshake: a request is offered while data_req=1 and is accepted in the
//   cycle where data_req=1 and data_addr_ok=1. While data_req=1 and no
//   acceptance has happened, data_wr/data_size/data_addr/data_wstrb/data_wdata
//   hold their values.
//
//   Ports (signals):
//     data_req     request valid
//     data_wr      1 = store, 0 = load
//     data_size    0 byte, 1 half, 2 word
//     data_addr    request address
//     data_wstrb   byte strobes (0 for loads)
//     data_wdata   store data, replicated across byte lanes
//     data_addr_ok request accepted this cycle
interface pre_mem_stage_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok
    );
endinterface

// File: rtl/pre_mem_stage.sv
// pre_mem_stage
//   Pipeline stage between EXE and MEM. Latches the EXE result, checks the
//   alignment of loads/stores, issues the data-memory request and hands the
//   instruction (with any exception) to MEM. A flush never abandons a request
//   already on the bus: the stage waits for its acceptance (DRAIN) and pulses
//   discard_resp so MEM drops the matching response.
//
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     es_to_pms_valid/pms_allowin  EXE -> stage handoff (valid/ready)
//     es_*                       instruction fields from EXE
//     flush                      exception/eret flush
//     ms_allowin/pms_to_ms_valid stage -> MEM handoff (valid/ready)
//     ms_*                       registered fields to MEM
//     ms_req_sent                a request was accepted for this instruction
//     discard_resp               next data_ok belongs to a flushed request
//     pms_wr_disable             stage holds a valid excepting instruction
//     fwd_dest, fwd_is_load      forwarding / load-use information
//     dbus                       data-memory request bus (master side)
//     dbg_state                  FSM state (0 IDLE, 1 REQ, 2 DONE, 3 DRAIN)
module pre_mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_to_pms_valid,
    output logic        pms_allowin,
    input  logic [2:0]  es_load_op,
    input  logic [1:0]  es_store_op,
    input  logic [31:0] es_addr,
    input  logic [31:0] es_wdata,
    input  logic [4:0]  es_dest,
    input  logic [31:0] es_result,
    input  logic [31:0] es_pc,
    input  logic        es_ex,
    input  logic [4:0]  es_exccode,
    input  logic [31:0] es_badvaddr,
    input  logic        flush,
    input  logic        ms_allowin,
    output logic        pms_to_ms_valid,
    output logic [2:0]  ms_load_op,
    output logic [4:0]  ms_dest,
    output logic [31:0] ms_result,
    output logic [31:0] ms_pc,
    output logic [1:0]  ms_addr_low,
    output logic        ms_ex,
    output logic [4:0]  ms_exccode,
    output logic [31:0] ms_badvaddr,
    output logic        ms_req_sent,
    output logic        discard_resp,
    output logic        pms_wr_disable,
    output logic [4:0]  fwd_dest,
    output logic        fwd_is_load,
    pre_mem_stage_if.master dbus,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic        pms_valid;
    logic [1:0]  st_op;
    logic [31:0] addr_q;
    logic [31:0] rt_q;

    // Decode of the incoming instruction, used only at capture time.
    logic es_half, es_word, es_is_store, es_mem_op, es_misalign, es_need_req;
    logic capture;

    assign es_half     = (es_load_op == 3'd3) || (es_load_op == 3'd4) || (es_store_op == 2'd2);
    assign es_word     = (es_load_op == 3'd5) || (es_store_op == 2'd3);
    assign es_is_store = (es_store_op != 2'd0);
    assign es_mem_op   = (es_load_op != 3'd0) || es_is_store;
    assign es_misalign = (es_half && es_addr[0]) || (es_word && (es_addr[1:0] != 2'b00));
    assign es_need_req = es_mem_op && !es_ex && !es_misalign;

    // A flush cycle never captures, even if pms_allowin is reported high.
    assign capture = es_to_pms_valid && pms_allowin && !flush;

    // Decode of the held instruction.
    logic mem_op, need_req, ready_go, held_half, held_word;

    assign mem_op    = (ms_load_op != 3'd0) || (st_op != 2'd0);
    assign need_req  = pms_valid && mem_op && !ms_ex;
    assign held_half = (ms_load_op == 3'd3) || (ms_load_op == 3'd4) || (st_op == 2'd2);
    assign held_word = (ms_load_op == 3'd5) || (st_op == 2'd3);

    assign ready_go = pms_valid &&
                      (!need_req || (state == DONE) || ((state == REQ) && dbus.data_addr_ok));

    assign pms_to_ms_valid = ready_go && !flush;
    assign pms_allowin     = (state != DRAIN) && (!pms_valid || (ready_go && ms_allowin));
    assign ms_req_sent     = mem_op && !ms_ex;
    assign pms_wr_disable  = pms_valid && ms_ex;
    assign fwd_dest        = pms_valid ? ms_dest : 5'd0;
    assign fwd_is_load     = pms_valid && (ms_load_op != 3'd0);
    assign ms_addr_low     = addr_q[1:0];
    assign dbg_state       = state;

    // A response is discarded when the request that produces it is accepted
    // after (or in the same cycle as) a flush.
    assign discard_resp = dbus.data_addr_ok &&
                          (((state == REQ) && flush) || (state == DRAIN));

    // Request bus: driven purely from captured fields, so it cannot change
    // while waiting for acceptance (no capture happens in REQ/DRAIN until
    // the request is accepted).
    assign dbus.data_req   = (state == REQ) || (state == DRAIN);
    assign dbus.data_wr    = (st_op != 2'd0);
    assign dbus.data_size  = held_word ? 2'd2 : (held_half ? 2'd1 : 2'd0);
    assign dbus.data_addr  = addr_q;

    always_comb begin
        dbus.data_wstrb = 4'b0000;
        dbus.data_wdata = rt_q;
        case (st_op)
            2'd1: begin
                dbus.data_wstrb = 4'b0001 << addr_q[1:0];
                dbus.data_wdata = {4{rt_q[7:0]}};
            end
            2'd2: begin
                dbus.data_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
                dbus.data_wdata = {2{rt_q[15:0]}};
            end
            2'd3: dbus.data_wstrb = 4'b1111;
            default: ;
        endcase
    end

    // Next state. An accepted request whose instruction is handed off in the
    // same cycle falls through the pms_allowin branch (back-to-back issue);
    // if MEM is blocked it parks in DONE.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            if ((state == REQ) || (state == DRAIN))
                state_nxt = dbus.data_addr_ok ? IDLE : DRAIN;
            else
                state_nxt = IDLE;
        end else if (pms_allowin) begin
            state_nxt = (capture && es_need_req) ? REQ : IDLE;
        end else if ((state == REQ) && dbus.data_addr_ok) begin
            state_nxt = DONE;
        end else if ((state == DRAIN) && dbus.data_addr_ok) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pms_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush)
                pms_valid <= 1'b0;
            else if (pms_allowin)
                pms_valid <= es_to_pms_valid;
        end
    end

    // Data fields are not reset; they are qualified by pms_valid.
    always_ff @(posedge clk) begin
        if (capture) begin
            ms_load_op  <= es_load_op;
            st_op       <= es_store_op;
            addr_q      <= es_addr;
            rt_q        <= es_wdata;
            ms_dest     <= es_dest;
            ms_result   <= es_result;
            ms_pc       <= es_pc;
            ms_ex       <= es_ex || es_misalign;
            // Upstream exceptions keep their own code and bad address.
            ms_exccode  <= es_ex ? es_exccode : (es_is_store ? 5'd5 : 5'd4);
            ms_badvaddr <= es_ex ? es_badvaddr : es_addr;
        end
    end

endmodule

// File: tb/tb_pre_mem_stage.sv
module tb_pre_mem_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        es_to_pms_valid;
    logic        pms_allowin;
    logic [2:0]  es_load_op;
    logic [1:0]  es_store_op;
    logic [31:0] es_addr, es_wdata, es_result, es_pc, es_badvaddr;
    logic [4:0]  es_dest, es_exccode;
    logic        es_ex;
    logic        flush;
    logic        ms_allowin;
    logic        pms_to_ms_valid;
    logic [2:0]  ms_load_op;
    logic [4:0]  ms_dest;
    logic [31:0] ms_result, ms_pc, ms_badvaddr;
    logic [1:0]  ms_addr_low;
    logic        ms_ex;
    logic [4:0]  ms_exccode;
    logic        ms_req_sent, discard_resp, pms_wr_disable, fwd_is_load;
    logic [4:0]  fwd_dest;
    logic [1:0]  dbg_state;

    pre_mem_stage_if dbus();

    pre_mem_stage dut (
        .clk(clk), .reset(reset),
        .es_to_pms_valid(es_to_pms_valid), .pms_allowin(pms_allowin),
        .es_load_op(es_load_op), .es_store_op(es_store_op), .es_addr(es_addr),
        .es_wdata(es_wdata), .es_dest(es_dest), .es_result(es_result), .es_pc(es_pc),
        .es_ex(es_ex), .es_exccode(es_exccode), .es_badvaddr(es_badvaddr),
        .flush(flush), .ms_allowin(ms_allowin), .pms_to_ms_valid(pms_to_ms_valid),
        .ms_load_op(ms_load_op), .ms_dest(ms_dest), .ms_result(ms_result), .ms_pc(ms_pc),
        .ms_addr_low(ms_addr_low), .ms_ex(ms_ex), .ms_exccode(ms_exccode),
        .ms_badvaddr(ms_badvaddr), .ms_req_sent(ms_req_sent), .discard_resp(discard_resp),
        .pms_wr_disable(pms_wr_disable), .fwd_dest(fwd_dest), .fwd_is_load(fwd_is_load),
        .dbus(dbus), .dbg_state(dbg_state)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    // ---------------- reference model (access rules) ----------------
    function automatic int unsigned acc_bytes(input logic [2:0] lop, input logic [1:0] sop);
        if (lop == 3'd1 || lop == 3'd2 || sop == 2'd1) return 1;
        if (lop == 3'd3 || lop == 3'd4 || sop == 2'd2) return 2;
        if (lop == 3'd5 || sop == 2'd3) return 4;
        return 0;
    endfunction

    function automatic logic [1:0] model_size(input logic [2:0] lop, input logic [1:0] sop);
        return 2'(acc_bytes(lop, sop) / 2);
    endfunction

    function automatic bit model_misaligned(input logic [2:0] lop, input logic [1:0] sop,
                                            input logic [31:0] addr);
        int unsigned b;
        b = acc_bytes(lop, sop);
        return (b != 0) && ((addr % b) != 0);
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [2:0] lop, input logic [1:0] sop,
                                               input logic [31:0] addr);
        int unsigned b;
        b = acc_bytes(lop, sop);
        if (sop == 2'd0) return 4'b0000;
        return 4'(((32'd1 << b) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] lop, input logic [1:0] sop,
                                                input logic [31:0] rt);
        int unsigned b;
        b = acc_bytes(lop, sop);
        if (b == 1) return (rt & 32'hff) * 32'h0101_0101;
        if (b == 2) return (rt & 32'hffff) * 32'h0001_0001;
        return rt;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        es_to_pms_valid = 1'b0;
        es_load_op = 3'd0; es_store_op = 2'd0;
        es_addr = 32'd0; es_wdata = 32'd0; es_dest = 5'd0; es_result = 32'd0;
        es_pc = 32'd0; es_ex = 1'b0; es_exccode = 5'd0; es_badvaddr = 32'd0;
    endtask

    task automatic drive_instr(input logic [2:0] lop, input logic [1:0] sop,
                               input logic [31:0] addr, input logic [31:0] rt,
                               input logic [4:0] dest, input logic [31:0] result,
                               input logic [31:0] pc);
        es_to_pms_valid = 1'b1;
        es_load_op = lop; es_store_op = sop; es_addr = addr; es_wdata = rt;
        es_dest = dest; es_result = result; es_pc = pc;
        es_ex = 1'b0; es_exccode = 5'd0; es_badvaddr = 32'd0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; ms_allowin = 1'b1; dbus.data_addr_ok = 1'b0;
        drive_instr(3'd5, 2'd0, 32'h1000_0000, 32'd0, 5'd4, 32'd0, 32'h100);
        tick(); tick();
        drive_idle();
        @(negedge clk);
        checks++; if (dbus.data_req !== 1'b0) begin failures++; $display("FAIL reset_data_req got=%b exp=0", dbus.data_req); end
        checks++; if (discard_resp !== 1'b0) begin failures++; $display("FAIL reset_discard got=%b exp=0", discard_resp); end
        checks++; if (pms_to_ms_valid !== 1'b0) begin failures++; $display("FAIL reset_to_ms_valid got=%b exp=0", pms_to_ms_valid); end
        checks++; if (pms_wr_disable !== 1'b0) begin failures++; $display("FAIL reset_wr_disable got=%b exp=0", pms_wr_disable); end
        checks++; if (fwd_is_load !== 1'b0) begin failures++; $display("FAIL reset_fwd_is_load got=%b exp=0", fwd_is_load); end
        checks++; if (fwd_dest !== 5'd0) begin failures++; $display("FAIL reset_fwd_dest got=%0d exp=0", fwd_dest); end
        checks++; if (pms_allowin !== 1'b1) begin failures++; $display("FAIL reset_allowin got=%b exp=1", pms_allowin); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_lw();
        ms_allowin = 1'b1; dbus.data_addr_ok = 1'b1;
        drive_instr(3'd5, 2'd0, 32'h1000_0004, 32'd0, 5'd3, 32'd0, 32'hbfc0_0100);
        @(negedge clk);
        checks++; if (pms_allowin !== 1'b1) begin failures++; $display("FAIL lw_allowin_idle got=%b exp=1", pms_allowin); end
        tick();
        drive_idle();
        @(negedge clk);
        checks++; if (dbus.data_req !== 1'b1) begin failures++; $display("FAIL lw_req got=%b exp=1", dbus.data_req); end
        checks++; if (dbus.data_wr !== 1'b0) begin failures++; $display("FAIL lw_wr got=%b exp=0", dbus.data_wr); end
        checks++; if (dbus.data_size !== 2'd2) begin failures++; $display("FAIL lw_size got=%0d exp=2", dbus.data_size); end
        checks++; if (dbus.data_wstrb !== 4'b0000) begin failures++; $display("FAIL lw_wstrb got=%b exp=0000", dbus.data_wstrb); end
        checks++; if (dbus.data_addr !== 32'h1000_0004) begin failures++; $display("FAIL lw_addr got=%h exp=10000004", dbus.data_addr); end
        checks++; if (pms_to_ms_valid !== 1'b1) begin failures++; $display("FAIL lw_handoff got=%b exp=1", pms_to_ms_valid); end
        checks++; if (ms_req_sent !== 1'b1) begin failures++; $display("FAIL lw_req_sent got=%b exp=1", ms_req_sent); end
        checks++; if (fwd_is_load !== 1'b1) begin failures++; $display("FAIL lw_fwd_is_load got=%b exp=1", fwd_is_load); end
        checks++; if (ms_pc !== 32'hbfc0_0100) begin failures++; $display("FAIL lw_pc got=%h exp=bfc00100", ms_pc); end
        tick();
        dbus.data_addr_ok = 1'b0;
        @(negedge clk);
        checks++; if (dbus.data_req !== 1'b0 || pms_to_ms_valid !== 1'b0) begin failures++; $display("FAIL lw_after got=%b%b exp=00", dbus.data_req, pms_to_ms_valid); end
    endtask

    task automatic test_store_lanes();
        logic [1:0]  sops[2]  = '{2'd1, 2'd2};
        logic [31:0] addrs[2] = '{32'h2000_0003, 32'h2000_0002};
        logic [31:0] rts[2]   = '{32'h0000_00A5, 32'h0000_1234};
        logic [3:0]  strbs[2] = '{4'b1000, 4'b1100};
        logic [31:0] wds[2]   = '{32'hA5A5_A5A5, 32'h1234_1234};
        ms_allowin = 1'b1; dbus.data_addr_ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_instr(3'd0, sops[i], addrs[i], rts[i], 5'd0, 32'd0, 32'h200 + 32'(i * 4));
            tick();
            drive_idle();
            @(negedge clk);
            checks++; if (dbus.data_req !== 1'b1 || dbus.data_wr !== 1'b1) begin failures++; $display("FAIL store%0d_req got=%b%b exp=11", i, dbus.data_req, dbus.data_wr); end
            checks++; if (dbus.data_wstrb !== strbs[i]) begin failures++; $display("FAIL store%0d_wstrb got=%b exp=%b", i, dbus.data_wstrb, strbs[i]); end
            checks++; if (dbus.data_wdata !== wds[i]) begin failures++; $display("FAIL store%0d_wdata got=%h exp=%h", i, dbus.data_wdata, wds[i]); end
            checks++; if (dbus.data_size !== 2'(i)) begin failures++; $display("FAIL store%0d_size got=%0d exp=%0d", i, dbus.data_size, i); end
            tick();
        end
        dbus.data_addr_ok = 1'b0;
    endtask

    task automatic test_misaligned();
        logic [2:0]  lops[2]  = '{3'd3, 3'd0};
        logic [1:0]  sops[2]  = '{2'd0, 2'd3};
        logic [31:0] addrs[2] = '{32'h3000_0001, 32'h3000_0002};
        logic [4:0]  codes[2] = '{5'd4, 5'd5};
        ms_allowin = 1'b1; dbus.data_addr_ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_instr(lops[i], sops[i], addrs[i], 32'h5555_5555, 5'd7, 32'd0, 32'h300);
            tick();
            drive_idle();
            @(negedge clk);
            checks++; if (dbus.data_req !== 1'b0) begin failures++; $display("FAIL mis%0d_req got=%b exp=0", i, dbus.data_req); end
            checks++; if (ms_ex !== 1'b1 || pms_wr_disable !== 1'b1) begin failures++; $display("FAIL mis%0d_ex got=%b%b exp=11", i, ms_ex, pms_wr_disable); end
            checks++; if (ms_exccode !== codes[i]) begin failures++; $display("FAIL mis%0d_code got=%0d exp=%0d", i, ms_exccode, codes[i]); end
            checks++; if (ms_badvaddr !== addrs[i]) begin failures++; $display("FAIL mis%0d_badv got=%h exp=%h", i, ms_badvaddr, addrs[i]); end
            checks++; if (pms_to_ms_valid !== 1'b1 || ms_req_sent !== 1'b0) begin failures++; $display("FAIL mis%0d_handoff got=%b%b exp=10", i, pms_to_ms_valid, ms_req_sent); end
            tick();
        end
        dbus.data_addr_ok = 1'b0;
    endtask

    task automatic test_addr_stall();
        ms_allowin = 1'b1; dbus.data_addr_ok = 1'b0;
        drive_instr(3'd0, 2'd3, 32'h4000_0008, 32'hDEAD_BEEF, 5'd0, 32'd0, 32'h400);
        tick();
        // A following ADD waits at the stage input during the stall.
        drive_instr(3'd0, 2'd0, 32'd0, 32'd0, 5'd9, 32'h0000_0099, 32'h404);
        for (int c = 0; c < 4; c++) begin
            dbus.data_addr_ok = (c == 3);
            @(negedge clk);
            checks++; if (dbus.data_req !== 1'b1) begin failures++; $display("FAIL stall_req c=%0d got=%b exp=1", c, dbus.data_req); end
            checks++; if (dbus.data_addr !== 32'h4000_0008 || dbus.data_wdata !== 32'hDEAD_BEEF || dbus.data_wstrb !== 4'b1111 || dbus.data_wr !== 1'b1 || dbus.data_size !== 2'd2)
                begin failures++; $display("FAIL stall_fields c=%0d got=%h/%h/%b exp=40000008/deadbeef/1111", c, dbus.data_addr, dbus.data_wdata, dbus.data_wstrb); end
            checks++; if (pms_to_ms_valid !== (c == 3)) begin failures++; $display("FAIL stall_handoff c=%0d got=%b exp=%b", c, pms_to_ms_valid, c == 3); end
            checks++; if (pms_allowin !== (c == 3)) begin failures++; $display("FAIL stall_allowin c=%0d got=%b exp=%b", c, pms_allowin, c == 3); end
            tick();
        end
        dbus.data_addr_ok = 1'b0;
        drive_idle();
        @(negedge clk);
        checks++; if (pms_to_ms_valid !== 1'b1 || ms_dest !== 5'd9 || ms_result !== 32'h99) begin failures++; $display("FAIL stall_next got=%b/%0d/%h exp=1/9/99", pms_to_ms_valid, ms_dest, ms_result); end
        tick();
    endtask

    task automatic test_flush_drain();
        ms_allowin = 1'b1; dbus.data_addr_ok = 1'b0; flush = 1'b0;
        drive_instr(3'd5, 2'd0, 32'h5000_0010, 32'd0, 5'd2, 32'd0, 32'h500);
        tick();
        // ADD presented throughout the drain must not be captured.
        drive_instr(3'd0, 2'd0, 32'd0, 32'd0, 5'd11, 32'h0000_0777, 32'h504);
        flush = 1'b1;
        @(negedge clk);
        checks++; if (dbus.data_req !== 1'b1) begin failures++; $display("FAIL flush_req got=%b exp=1", dbus.data_req); end
        checks++; if (pms_to_ms_valid !== 1'b0 || discard_resp !== 1'b0) begin failures++; $display("FAIL flush_cycle got=%b%b exp=00", pms_to_ms_valid, discard_resp); end
        tick();
        flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            dbus.data_addr_ok = (c == 2);
            @(negedge clk);
            checks++; if (dbus.data_req !== 1'b1 || pms_allowin !== 1'b0) begin failures++; $display("FAIL drain c=%0d got=req%b allow%b exp=req1 allow0", c, dbus.data_req, pms_allowin); end
            checks++; if (discard_resp !== (c == 2)) begin failures++; $display("FAIL drain_discard c=%0d got=%b exp=%b", c, discard_resp, c == 2); end
            checks++; if (pms_to_ms_valid !== 1'b0) begin failures++; $display("FAIL drain_handoff c=%0d got=%b exp=0", c, pms_to_ms_valid); end
            tick();
        end
        dbus.data_addr_ok = 1'b0;
        @(negedge clk);
        checks++; if (dbus.data_req !== 1'b0 || discard_resp !== 1'b0 || pms_to_ms_valid !== 1'b0 || pms_allowin !== 1'b1)
            begin failures++; $display("FAIL drain_done got=%b%b%b%b exp=0001", dbus.data_req, discard_resp, pms_to_ms_valid, pms_allowin); end
        tick();
        drive_idle();
        @(negedge clk);
        checks++; if (pms_to_ms_valid !== 1'b1 || ms_dest !== 5'd11) begin failures++; $display("FAIL drain_next got=%b/%0d exp=1/11", pms_to_ms_valid, ms_dest); end
        tick();
        // Flush in the same cycle as acceptance: single discard pulse, back to idle.
        drive_instr(3'd1, 2'd0, 32'h5000_0021, 32'd0, 5'd2, 32'd0, 32'h508);
        tick();
        drive_idle();
        flush = 1'b1; dbus.data_addr_ok = 1'b1;
        @(negedge clk);
        checks++; if (discard_resp !== 1'b1 || pms_to_ms_valid !== 1'b0) begin failures++; $display("FAIL flush_ok got=%b%b exp=10", discard_resp, pms_to_ms_valid); end
        tick();
        flush = 1'b0;
        @(negedge clk);
        checks++; if (dbus.data_req !== 1'b0 || discard_resp !== 1'b0) begin failures++; $display("FAIL flush_ok_after got=%b%b exp=00", dbus.data_req, discard_resp); end
        dbus.data_addr_ok = 1'b0;
        // Flush while idle blocks capture.
        drive_instr(3'd0, 2'd0, 32'd0, 32'd0, 5'd12, 32'd0, 32'h50c);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive_idle();
        @(negedge clk);
        checks++; if (pms_to_ms_valid !== 1'b0 || fwd_dest !== 5'd0) begin failures++; $display("FAIL flush_capture got=%b/%0d exp=0/0", pms_to_ms_valid, fwd_dest); end
        tick();
    endtask

    task automatic test_mem_stall();
        dbus.data_addr_ok = 1'b0; ms_allowin = 1'b0;
        drive_instr(3'd0, 2'd0, 32'd0, 32'd0, 5'd8, 32'h0000_ABCD, 32'h600);
        tick();
        drive_idle();
        for (int c = 0; c < 3; c++) begin
            ms_allowin = (c == 2);
            @(negedge clk);
            checks++; if (pms_to_ms_valid !== 1'b1 || fwd_dest !== 5'd8 || ms_result !== 32'hABCD) begin failures++; $display("FAIL mstall c=%0d got=%b/%0d/%h exp=1/8/abcd", c, pms_to_ms_valid, fwd_dest, ms_result); end
            checks++; if (pms_allowin !== (c == 2)) begin failures++; $display("FAIL mstall_allowin c=%0d got=%b exp=%b", c, pms_allowin, c == 2); end
            tick();
        end
        @(negedge clk);
        checks++; if (pms_to_ms_valid !== 1'b0 || fwd_dest !== 5'd0) begin failures++; $display("FAIL mstall_gone got=%b/%0d exp=0/0", pms_to_ms_valid, fwd_dest); end
        // Load accepted while MEM blocked: request ends, result waits.
        ms_allowin = 1'b0;
        drive_instr(3'd4, 2'd0, 32'h6000_0002, 32'd0, 5'd6, 32'd0, 32'h604);
        tick();
        drive_idle();
        dbus.data_addr_ok = 1'b1;
        @(negedge clk);
        checks++; if (dbus.data_req !== 1'b1 || pms_to_ms_valid !== 1'b1 || pms_allowin !== 1'b0) begin failures++; $display("FAIL ldstall_acc got=%b%b%b exp=110", dbus.data_req, pms_to_ms_valid, pms_allowin); end
        tick();
        dbus.data_addr_ok = 1'b0;
        @(negedge clk);
        checks++; if (dbus.data_req !== 1'b0 || pms_to_ms_valid !== 1'b1 || fwd_is_load !== 1'b1) begin failures++; $display("FAIL ldstall_done got=%b%b%b exp=011", dbus.data_req, pms_to_ms_valid, fwd_is_load); end
        ms_allowin = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (pms_to_ms_valid !== 1'b0 || fwd_is_load !== 1'b0) begin failures++; $display("FAIL ldstall_gone got=%b%b exp=00", pms_to_ms_valid, fwd_is_load); end
    endtask

    task automatic test_random(input int n);
        logic [2:0]  lop;
        logic [1:0]  sop;
        logic [31:0] addr, rt, pc, up_bad;
        logic [4:0]  up_code, dest;
        bit          up_ex, mis, ex, mem;
        int          kind, k;
        logic [4:0]  exp_code;
        logic [31:0] exp_bad;
        ms_allowin = 1'b1; dbus.data_addr_ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            kind = $urandom_range(0, 2);
            lop = 3'd0; sop = 2'd0;
            if (kind == 0) lop = 3'($urandom_range(1, 5));
            else if (kind == 1) sop = 2'($urandom_range(1, 3));
            addr = $urandom; rt = $urandom; pc = $urandom; dest = 5'($urandom);
            up_ex = ($urandom_range(0, 5) == 0); up_code = 5'($urandom); up_bad = $urandom;
            mem = (acc_bytes(lop, sop) != 0);
            mis = model_misaligned(lop, sop, addr);
            ex = up_ex || mis;
            exp_code = up_ex ? up_code : ((sop != 2'd0) ? 5'd5 : 5'd4);
            exp_bad = up_ex ? up_bad : addr;
            drive_instr(lop, sop, addr, rt, dest, rt ^ 32'h0f0f_0f0f, pc);
            es_ex = up_ex; es_exccode = up_code; es_badvaddr = up_bad;
            tick();
            drive_idle();
            if (mem && !ex) begin
                k = $urandom_range(0, 2);
                for (int c = 0; c <= k; c++) begin
                    dbus.data_addr_ok = (c == k);
                    @(negedge clk);
                    checks++; if (dbus.data_req !== 1'b1 || dbus.data_addr !== addr || dbus.data_wr !== (sop != 2'd0) || dbus.data_size !== model_size(lop, sop))
                        begin failures++; $display("FAIL rnd%0d_req c=%0d got=%b/%h/%b/%0d exp=1/%h/%b/%0d", i, c, dbus.data_req, dbus.data_addr, dbus.data_wr, dbus.data_size, addr, sop != 2'd0, model_size(lop, sop)); end
                    checks++; if (dbus.data_wstrb !== model_wstrb(lop, sop, addr)) begin failures++; $display("FAIL rnd%0d_wstrb got=%b exp=%b", i, dbus.data_wstrb, model_wstrb(lop, sop, addr)); end
                    if (sop != 2'd0) begin
                        checks++; if (dbus.data_wdata !== model_wdata(lop, sop, rt)) begin failures++; $display("FAIL rnd%0d_wdata got=%h exp=%h", i, dbus.data_wdata, model_wdata(lop, sop, rt)); end
                    end
                    checks++; if (pms_to_ms_valid !== (c == k)) begin failures++; $display("FAIL rnd%0d_handoff c=%0d got=%b exp=%b", i, c, pms_to_ms_valid, c == k); end
                    tick();
                end
                dbus.data_addr_ok = 1'b0;
            end else begin
                @(negedge clk);
                checks++; if (dbus.data_req !== 1'b0 || pms_to_ms_valid !== 1'b1) begin failures++; $display("FAIL rnd%0d_noreq got=%b%b exp=01", i, dbus.data_req, pms_to_ms_valid); end
                checks++; if (ms_ex !== ex || pms_wr_disable !== ex || ms_req_sent !== (mem && !ex)) begin failures++; $display("FAIL rnd%0d_ex got=%b%b%b exp=%b%b%b", i, ms_ex, pms_wr_disable, ms_req_sent, ex, ex, mem && !ex); end
                if (ex) begin
                    checks++; if (ms_exccode !== exp_code || ms_badvaddr !== exp_bad) begin failures++; $display("FAIL rnd%0d_code got=%0d/%h exp=%0d/%h", i, ms_exccode, ms_badvaddr, exp_code, exp_bad); end
                end
                checks++; if (ms_pc !== pc || fwd_dest !== dest || fwd_is_load !== (lop != 3'd0)) begin failures++; $display("FAIL rnd%0d_fields got=%h/%0d/%b exp=%h/%0d/%b", i, ms_pc, fwd_dest, fwd_is_load, pc, dest, lop != 3'd0); end
                tick();
            end
        end
    endtask

    task automatic test_back_to_back(input int n);
        logic [31:0] addr, exp_addr;
        bit          is_ld;
        ms_allowin = 1'b1; dbus.data_addr_ok = 1'b1;
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                addr = $urandom & 32'hffff_fffc;
                is_ld = ($urandom_range(0, 1) == 1);
                exp_q.push_back(addr);
                drive_instr(is_ld ? 3'd5 : 3'd0, is_ld ? 2'd0 : 2'd3, addr, $urandom, 5'd1, 32'd0, 32'h700);
            end else begin
                drive_idle();
            end
            if (i > 0) begin
                @(negedge clk);
                exp_addr = exp_q.pop_front();
                checks++; if (dbus.data_req !== 1'b1 || dbus.data_addr !== exp_addr) begin failures++; $display("FAIL b2b%0d got=%b/%h exp=1/%h", i, dbus.data_req, dbus.data_addr, exp_addr); end
                checks++; if (pms_to_ms_valid !== 1'b1 || pms_allowin !== 1'b1) begin failures++; $display("FAIL b2b%0d_hs got=%b%b exp=11", i, pms_to_ms_valid, pms_allowin); end
            end
            tick();
        end
        dbus.data_addr_ok = 1'b0;
        @(negedge clk);
        checks++; if (dbus.data_req !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL b2b_end got=%b/%0d exp=0/0", dbus.data_req, exp_q.size()); end
    endtask

    task automatic test_reset_mid_req();
        ms_allowin = 1'b1; dbus.data_addr_ok = 1'b0;
        drive_instr(3'd5, 2'd0, 32'h8000_0000, 32'd0, 5'd5, 32'd0, 32'h800);
        tick();
        drive_idle();
        @(negedge clk);
        checks++; if (dbus.data_req !== 1'b1) begin failures++; $display("FAIL rstreq_pre got=%b exp=1", dbus.data_req); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (dbus.data_req !== 1'b0 || pms_to_ms_valid !== 1'b0 || fwd_is_load !== 1'b0 || fwd_dest !== 5'd0)
            begin failures++; $display("FAIL rstreq_post got=%b%b%b/%0d exp=000/0", dbus.data_req, pms_to_ms_valid, fwd_is_load, fwd_dest); end
        tick();
    endtask

    initial begin
        drive_idle();
        reset = 1'b1; flush = 1'b0; ms_allowin = 1'b1; dbus.data_addr_ok = 1'b0;
        test_reset();
        test_lw();
        test_store_lanes();
        test_misaligned();
        test_addr_stall();
        test_flush_drain();
        test_mem_stall();
        test_random(60);
        test_back_to_back(10);
        test_reset_mid_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
